// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one fixed-point divider among N requesters.
// Optional WAIT watchdog enabled by defining DIVARB_TIMEOUT_EN.
module div_share_arb #(
    parameter int N       = 4,
    parameter int W       = 10,
    parameter int TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         gnt,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_q,
    output logic [1:0]           rsp_status,
    output logic                 div_start,
    output logic                 div_sclr,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    input  logic                 div_valid,
    input  logic                 div_ovf,
    input  logic [W-1:0]         div_q
);

    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_GRANT, S_START, S_WAIT, S_RESP
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, idx, sel_idx, cand;
    logic          sel_found;
    logic [W-1:0]  q_r;
    logic [1:0]    status_r;
    logic          timeout_hit;

    // First requesting index at or above ptr, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef DIVARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Counter holds completed WAIT cycles; the check includes the current one,
    // so expiry lands on the TIMEOUT-th WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wait_cnt <= '0;
        else if (state == S_START)  wait_cnt <= '0;
        else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == S_WAIT) && !div_valid &&
                         (({1'b0, wait_cnt} + 1'b1) == (CW + 1)'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FLUSH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FLUSH: state_nxt = S_IDLE;
            S_IDLE:  if (sel_found) state_nxt = S_GRANT;
            S_GRANT: state_nxt = (div_b == '0) ? S_RESP : S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (div_valid || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_FLUSH;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == S_GRANT) gnt[idx] = 1'b1;
        div_start  = (state == S_START);
        div_sclr   = !rst_n || (state == S_FLUSH) || timeout_hit;
        rsp_valid  = (state == S_RESP);
        rsp_id     = rsp_valid ? idx : '0;
        rsp_q      = rsp_valid ? q_r : '0;
        rsp_status = rsp_valid ? status_r : 2'b00;
    end

    // Operands are captured only in IDLE, so they stay put until RESP is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            idx      <= '0;
            div_a    <= '0;
            div_b    <= '0;
            q_r      <= '0;
            status_r <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        idx   <= sel_idx;
                        div_a <= req_a[int'(sel_idx)*W +: W];
                        div_b <= req_b[int'(sel_idx)*W +: W];
                    end
                end
                S_GRANT: begin
                    ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
                    if (div_b == '0) begin
                        q_r      <= '0;
                        status_r <= 2'b10;
                    end
                end
                S_WAIT: begin
                    if (div_valid) begin
                        q_r      <= div_q;
                        status_r <= {1'b0, div_ovf};
                    end else if (timeout_hit) begin
                        q_r      <= '0;
                        status_r <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
